// File: rtl/fx_regbank_if.sv
//----------------------------------------------------------------------------
// fx_regbank_if : fx bus bundle (write strobe/address/data, read strobe/address, read data)
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface fx_regbank_if;
  logic        fx_wr;
  logic [15:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [15:0] fx_raddr;
  logic [7:0]  fx_q;

  modport master (output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, input fx_q);
  modport slave  (input fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, output fx_q);
endinterface

`default_nettype wire

// File: rtl/fx_regbank.sv
//----------------------------------------------------------------------------
// fx_regbank : shadowed config bytes with atomic commit, sticky status + irq,
//              registered read path. FX_REGBANK_COR_EN: status clear-on-read.
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fx_regbank #(
  parameter int                NREG     = 16,
  parameter logic [7:0]        CFG_BASE = 8'h40,
  parameter int                NSTS     = 2,
  parameter logic [7:0]        STS_BASE = 8'h10,
  parameter logic [NREG*8-1:0] RST_VAL  = '0
) (
  input  wire logic              clk_sys,
  input  wire logic              rst_n,
  input  wire logic [5:0]        mod_id,
  fx_regbank_if.slave            fx,
  output      logic [NREG*8-1:0] cfg_q,
  output      logic              cfg_upd,
  input  wire logic [NSTS*8-1:0] sts_set,
  output      logic              irq
);

  localparam logic [7:0] C_ADDR_ID   = 8'h00;
  localparam logic [7:0] C_ADDR_CTRL = 8'h01;
  localparam logic [7:0] C_ADDR_IEN  = 8'h02;

  logic [NREG*8-1:0] shadow_q, shadow_d;
  logic [NREG*8-1:0] cfg_reg_q, cfg_reg_d;
  logic              cfg_upd_q, cfg_upd_d;
  logic [NSTS*8-1:0] sticky_q, sticky_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;
  logic [7:0]        rdata_q, rdata_d;

  logic              we, re, pending, commit;
  logic [7:0]        wlo, rlo, rd_val;
  logic [NSTS*8-1:0] sts_clr;
  logic              unused_addr_hi;

  assign wlo            = fx.fx_waddr[7:0];
  assign rlo            = fx.fx_raddr[7:0];
  assign we             = fx.fx_wr & (fx.fx_waddr[13:8] == mod_id);
  assign re             = fx.fx_rd & (fx.fx_raddr[13:8] == mod_id);
  assign pending        = (shadow_q != cfg_reg_q);
  assign commit         = we && (wlo == C_ADDR_CTRL) && fx.fx_data[0];
  assign unused_addr_hi = ^{fx.fx_waddr[15:14], fx.fx_raddr[15:14]};

  always_comb begin
    shadow_d  = shadow_q;
    cfg_reg_d = commit ? shadow_q : cfg_reg_q;
    cfg_upd_d = commit;
    irq_en_d  = irq_en_q;
    if (we && (wlo == C_ADDR_IEN)) irq_en_d = fx.fx_data[0];
    for (int i = 0; i < NREG; i++) begin
      if (we && (wlo == 8'(CFG_BASE + i))) shadow_d[i*8 +: 8] = fx.fx_data;
    end

    sts_clr = '0;
    for (int j = 0; j < NSTS; j++) begin
`ifdef FX_REGBANK_COR_EN
      if (re && (rlo == 8'(STS_BASE + j))) sts_clr[j*8 +: 8] = 8'hFF;
`else
      if (we && (wlo == 8'(STS_BASE + j))) sts_clr[j*8 +: 8] = fx.fx_data;
`endif
    end
    // OR-ing sts_set last makes a coincident set win over any clear
    sticky_d = (sticky_q & ~sts_clr) | sts_set;
    irq_d    = irq_en_q & (|sticky_q);

    rd_val = 8'h00;
    case (rlo)
      C_ADDR_ID:   rd_val = {2'b00, mod_id};
      C_ADDR_CTRL: rd_val = {7'b0, pending};
      C_ADDR_IEN:  rd_val = {7'b0, irq_en_q};
      default:     rd_val = 8'h00;
    endcase
    for (int i = 0; i < NREG; i++) begin
      if (rlo == 8'(CFG_BASE + i)) rd_val = shadow_q[i*8 +: 8];
    end
    for (int j = 0; j < NSTS; j++) begin
      if (rlo == 8'(STS_BASE + j)) rd_val = sticky_q[j*8 +: 8];
    end
    rdata_d = re ? rd_val : 8'h00;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= RST_VAL;
      cfg_reg_q <= RST_VAL;
      cfg_upd_q <= 1'b0;
      sticky_q  <= '0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      shadow_q  <= shadow_d;
      cfg_reg_q <= cfg_reg_d;
      cfg_upd_q <= cfg_upd_d;
      sticky_q  <= sticky_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cfg_q   = cfg_reg_q;
  assign cfg_upd = cfg_upd_q;
  assign irq     = irq_q;
  assign fx.fx_q = rdata_q;

endmodule

`default_nettype wire

// File: doc/fx_regbank.md
# fx_regbank

Parametrised fx-bus register bank: the successor to the per-module fixed-map config register blocks. It provides NREG shadowed 8-bit configuration bytes that are committed atomically, NSTS sticky status bytes with an interrupt output, and a registered read path. It sits between the fx bus and any module's datapath (AD, DA, trigger), selected by `mod_id`.

## Interface
- `NREG`, 16: number of configuration bytes (1..64).
- `CFG_BASE`, 8'h40: low address of configuration byte 0.
- `NSTS`, 2: number of status bytes (1..8).
- `STS_BASE`, 8'h10: low address of status byte 0.
- `RST_VAL`, {NREG*8{1'b0}}: reset value of shadow and committed config; byte i = bits [8i+7:8i].
- `clk_sys`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `mod_id`  in  6  module id, compared with address bits [13:8].
- `fx_wr`  in  1  write strobe, one byte per cycle.
- `fx_waddr`  in  16  write address.
- `fx_data`  in  8  write data.
- `fx_rd`  in  1  read strobe.
- `fx_raddr`  in  16  read address.
- `fx_q`  out  8  read data, registered.
- `cfg_q`  out  NREG*8  committed configuration.
- `cfg_upd`  out  1  one-cycle pulse when `cfg_q` changes by commit.
- `sts_set`  in  NSTS*8  per-bit set pulses from the datapath.
- `irq`  out  1  level interrupt.

## Operation
- Select: wsel = (fx_waddr[13:8]==mod_id), rsel likewise; accesses are ignored when unselected.
- Low-byte addresses: 8'h00 ID (RO, {2'b0,mod_id}); 8'h01 CTRL (W: bit0=1 commits; R: bit0=pending); 8'h02 IRQ_EN (RW, bit0); STS_BASE+j status j; CFG_BASE+i shadow i. All other addresses: writes are ignored, reads return 0.
- The parameter ranges must be disjoint from each other and from 8'h00–8'h02, with CFG_BASE+NREG ≤ 256. Violations are a configuration error, not handled in RTL.
- Config write: shadow[i] <= fx_data. `cfg_q` is unchanged.
- Commit: a write to CTRL with bit0=1 copies all shadow bytes into `cfg_q` at the same edge and sets `cfg_upd` for exactly that following cycle. The copy is unconditional, even if shadow equals cfg_q. A write with bit0=0 does nothing.
- pending = (shadow != cfg_q), computed combinationally and read via CTRL.
- Status: sticky[b] sets when sts_set[b]=1 at an edge. Writing 1 to a bit clears it (W1C). If set and clear occur in the same cycle, set wins.
- irq register <= irq_en & (|sticky).
- Read: fx_q <= mapped value when fx_rd & rsel, else 8'h00. Shadow is read back, not cfg_q.

## Timing
- Reset values: fx_q=0, cfg_q=RST_VAL, shadow=RST_VAL, cfg_upd=0, sticky=0, irq_en=0, irq=0.
- A write taking effect at edge k is visible to a read issued in cycle k+1.
- Read latency: fx_q is valid the cycle after fx_rd. Back-to-back reads return back-to-back data. fx_q returns to 0 the cycle after fx_rd drops.
- sts_set at edge k: sticky high after k, irq high after k+1. A W1C at edge m drops irq after m+1.
- A simultaneous read and write to the same register in one cycle returns the old value.
- Reset asserted mid-operation clears everything immediately, including a pending shadow. No commit occurs.

## Configuration
- `FX_REGBANK_COR_EN` defined: status bytes are clear-on-read. A read of STS_BASE+j returns the current value and clears that byte at the same edge, except bits set by sts_set in that cycle. Writes to status addresses are ignored.
- Not defined: W1C as above. Reads have no side effects.

## Test plan
- Reset, then read 8'h00 with mod_id=6'h05, addr 16'h0500 -> fx_q=8'h05 one cycle later. Read 16'h0540 -> RST_VAL byte 0. cfg_upd=0, irq=0.
- Write 8'hA5 to 16'h0541 -> cfg_q byte1 unchanged and CTRL reads 8'h01. Write 8'h01 to 16'h0501 -> cfg_q byte1=8'hA5, cfg_upd high one cycle, CTRL reads 8'h00.
- Write to 16'h0641 with mod_id=5 -> no change. Read 16'h06xx -> fx_q=0. Read unmapped 16'h05F0 -> 0.
- IRQ_EN=1, pulse sts_set bit 3 -> status0 reads 8'h08, irq high two edges after the pulse. Write 8'h08 to 16'h0510 -> status0=0, irq low. Repeat with set and clear in the same cycle -> bit stays 1.
- With `FX_REGBANK_COR_EN`: set bit 0, read 16'h0510 -> 8'h01, then a second read -> 8'h00. A set pulse coincident with the read -> the bit survives.
- Assert rst_n low after shadow writes, before commit -> all outputs back to reset values, with no cfg_upd pulse.
